// File: rtl/frame_painter.sv
// frame_painter
//   Framebuffer writer for the VGA block's write port (clk_33m domain).
//   After each frame swap (falling edge of rst_screen_33m) it optionally
//   clears the new write half to BG_PALETTE, then rasterises a queue of
//   filled rectangles one pixel per cycle.
//
//   Optional feature macro: FRAME_PAINTER_CLEAR_EN
//     defined   : background clear pass runs after every swap
//     undefined : swap goes straight to command processing
//
//   Ports
//     clk_33m, rst          clock, synchronous active-high reset
//     rst_screen_33m        swap window; high = stall, falling edge = swap
//     cmd_valid/cmd_ready   rectangle command push (valid/ready)
//     cmd_x/y/w/h/palette   rectangle top-left, size, fill colour
//     write_x/y/palette     pixel write to VGA block (palette 0 = no write)
//     busy                  painter is in CLEAR, LOAD or DRAW
//     frame_done            one-cycle pulse when the queue drains
//     overrun_count         saturating count of frames aborted by a swap
//     state_dbg             current FSM state
//
//   Handshake: a command is accepted on any rising clk_33m edge where
//   cmd_valid && cmd_ready; cmd_ready depends only on FIFO fullness and
//   never on cmd_valid.
module frame_painter #(
   parameter int         COOR_WIDTH = 12,
   parameter int         FRAME_W    = 1280,
   parameter int         FRAME_H    = 300,
   parameter int         CMD_DEPTH  = 8,
   parameter logic [1:0] BG_PALETTE = 2'd1
) (
   input  logic                  clk_33m,
   input  logic                  rst,
   input  logic                  rst_screen_33m,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [COOR_WIDTH-1:0] cmd_x,
   input  logic [COOR_WIDTH-1:0] cmd_y,
   input  logic [COOR_WIDTH-1:0] cmd_w,
   input  logic [COOR_WIDTH-1:0] cmd_h,
   input  logic [1:0]            cmd_palette,
   output logic [COOR_WIDTH-1:0] write_x,
   output logic [COOR_WIDTH-1:0] write_y,
   output logic [1:0]            write_palette,
   output logic                  busy,
   output logic                  frame_done,
   output logic [7:0]            overrun_count,
   output logic [1:0]            state_dbg
);

   localparam int CW = COOR_WIDTH;
   localparam int AW = $clog2(CMD_DEPTH);
   localparam int EW = 4 * CW + 2;
   localparam logic [CW:0] FW = (CW+1)'(FRAME_W);
   localparam logic [CW:0] FH = (CW+1)'(FRAME_H);

   typedef enum logic [1:0] {S_WAIT, S_CLEAR, S_LOAD, S_DRAW} state_t;

   // ---------------- command FIFO ----------------
   logic [EW-1:0] mem [CMD_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, push, pop;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;

   always_ff @(posedge clk_33m) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_palette};
   end

   always_ff @(posedge clk_33m) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Head-of-queue decode and clipping, one bit wider than coordinates so
   // x+w cannot wrap.
   logic [CW-1:0] h_x, h_y, h_w, h_h;
   logic [1:0]    h_pal;
   logic [CW:0]   x_sum, y_sum, x_lim, y_lim;
   logic          skip;

   assign {h_x, h_y, h_w, h_h, h_pal} = mem[rd_ptr[AW-1:0]];
   assign x_sum = {1'b0, h_x} + {1'b0, h_w};
   assign y_sum = {1'b0, h_y} + {1'b0, h_h};
   assign x_lim = (x_sum > FW) ? FW : x_sum;
   assign y_lim = (y_sum > FH) ? FH : y_sum;
   assign skip  = (h_w == '0) || (h_h == '0) || ({1'b0, h_x} >= FW) ||
                  ({1'b0, h_y} >= FH) || (h_pal == 2'd0);

   // ---------------- painter FSM ----------------
   state_t        state;
   logic          sw_d, sw_fall, stall, load_now;
   logic [CW-1:0] cx, cy, x_start;
   logic [CW:0]   x_end, y_end;
   logic [1:0]    pal_r;
   logic          last_col, last_row;

   assign stall    = rst_screen_33m;
   assign sw_fall  = sw_d && !rst_screen_33m;
   assign last_col = ({1'b0, cx} + 1'b1) == x_end;
   assign last_row = ({1'b0, cy} + 1'b1) == y_end;
   assign pop      = load_now && !empty;
   assign state_dbg = state;

`ifdef FRAME_PAINTER_CLEAR_EN
   localparam logic [CW-1:0] FW_M1 = CW'(FRAME_W - 1);
   localparam logic [CW-1:0] FH_M1 = CW'(FRAME_H - 1);
   logic [CW-1:0] clr_x, clr_y;
   // A swap emits pixel (0,0) on the very edge that sees it, so the clear
   // pass and its counters restart from the origin at that edge.
   assign clr_x    = sw_fall ? '0 : cx;
   assign clr_y    = sw_fall ? '0 : cy;
   assign load_now = !stall && !sw_fall && (state == S_LOAD);
`else
   // Without the clear pass a swap performs the first LOAD directly.
   assign load_now = !stall && (sw_fall || (state == S_LOAD));
`endif

   // Outputs are registered: each edge registers what the next cycle shows.
   always_ff @(posedge clk_33m) begin
      if (rst) begin
         state         <= S_WAIT;
         sw_d          <= 1'b0;
         cx            <= '0;
         cy            <= '0;
         x_start       <= '0;
         x_end         <= '0;
         y_end         <= '0;
         pal_r         <= 2'd0;
         write_x       <= '0;
         write_y       <= '0;
         write_palette <= 2'd0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         overrun_count <= 8'd0;
      end else begin
         sw_d          <= rst_screen_33m;
         write_palette <= 2'd0;
         frame_done    <= 1'b0;
         if (sw_fall && (state != S_WAIT) && (overrun_count != 8'hFF))
            overrun_count <= overrun_count + 8'd1;

         if (!stall) begin
            if (load_now) begin
               if (empty) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_WAIT;
               end else if (skip) begin
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end else begin
                  busy    <= 1'b1;
                  state   <= S_DRAW;
                  cx      <= h_x;
                  cy      <= h_y;
                  x_start <= h_x;
                  x_end   <= x_lim;
                  y_end   <= y_lim;
                  pal_r   <= h_pal;
               end
            end
`ifdef FRAME_PAINTER_CLEAR_EN
            else if (sw_fall || (state == S_CLEAR)) begin
               busy          <= 1'b1;
               write_x       <= clr_x;
               write_y       <= clr_y;
               write_palette <= BG_PALETTE;
               if (clr_x == FW_M1) begin
                  cx <= '0;
                  if (clr_y == FH_M1) begin
                     cy    <= '0;
                     state <= S_LOAD;
                  end else begin
                     cy    <= clr_y + 1'b1;
                     state <= S_CLEAR;
                  end
               end else begin
                  cx    <= clr_x + 1'b1;
                  cy    <= clr_y;
                  state <= S_CLEAR;
               end
            end
`endif
            else if (state == S_DRAW) begin
               write_x       <= cx;
               write_y       <= cy;
               write_palette <= pal_r;
               if (last_col) begin
                  cx <= x_start;
                  if (last_row) state <= S_LOAD;
                  else          cy    <= cy + 1'b1;
               end else begin
                  cx <= cx + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_painter.sv
module tb_frame_painter;

   localparam int CW    = 12;
   localparam int FW    = 16;
   localparam int FH    = 8;
   localparam int DEPTH = 8;
   localparam logic [1:0] BG = 2'd1;
   localparam int EW    = 28;   // {busy, frame_done, palette, x, y}

`ifdef FRAME_PAINTER_CLEAR_EN
   localparam int NCLR = FW * FH;
`else
   localparam int NCLR = 0;
`endif

   // ---------------- clock / reset ----------------
   logic          clk_33m = 1'b0;
   logic          rst = 1'b1;
   logic          rst_screen_33m = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
   logic [1:0]    cmd_palette = 2'd0;
   logic [CW-1:0] write_x, write_y;
   logic [1:0]    write_palette;
   logic          busy, frame_done;
   logic [7:0]    overrun_count;
   logic [1:0]    state_dbg;

   always #5 clk_33m = ~clk_33m;

   frame_painter #(
      .COOR_WIDTH(CW), .FRAME_W(FW), .FRAME_H(FH),
      .CMD_DEPTH(DEPTH), .BG_PALETTE(BG)
   ) dut (
      .clk_33m(clk_33m), .rst(rst), .rst_screen_33m(rst_screen_33m),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_palette(cmd_palette),
      .write_x(write_x), .write_y(write_y), .write_palette(write_palette),
      .busy(busy), .frame_done(frame_done), .overrun_count(overrun_count),
      .state_dbg(state_dbg)
   );

   // ---------------- reference model state ----------------
   typedef struct { int x; int y; int w; int h; int pal; } rect_t;
   rect_t          cmd_q[$];
   logic [EW-1:0]  exp_q[$];
   int             n_checks = 0;
   int             n_fail   = 0;
   int             exp_overrun = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_33m);
      #1;
   endtask

   task automatic push_cmd(input int x, input int y, input int w, input int h, input int pal);
      rect_t r;
      cmd_x = CW'(x); cmd_y = CW'(y); cmd_w = CW'(w); cmd_h = CW'(h);
      cmd_palette = 2'(pal);
      cmd_valid = 1'b1;
      check("cmd_ready", 32'(cmd_ready), 32'(cmd_q.size() < DEPTH));
      if (cmd_q.size() < DEPTH) begin
         r.x = x; r.y = y; r.w = w; r.h = h; r.pal = pal;
         cmd_q.push_back(r);
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic swap();
      rst_screen_33m = 1'b1;
      repeat (4) tick();
      rst_screen_33m = 1'b0;
   endtask

   function automatic logic [EW-1:0] item(input logic b, input logic d, input int pal,
                                          input int x, input int y);
      return {b, d, 2'(pal), 12'(x), 12'(y)};
   endfunction

   // Expected cycle stream for one frame: optional clear raster, then for
   // every queued command a LOAD cycle followed by its clipped pixels, then
   // the LOAD that finds the queue empty.
   task automatic build_frame();
      rect_t c;
      int xe, ye;
      exp_q.delete();
      for (int y = 0; y < NCLR / FW; y++)
         for (int x = 0; x < FW; x++)
            exp_q.push_back(item(1'b1, 1'b0, BG, x, y));
      while (cmd_q.size() > 0) begin
         c = cmd_q.pop_front();
         exp_q.push_back(item(1'b1, 1'b0, 0, 0, 0));
         if (c.w != 0 && c.h != 0 && c.x < FW && c.y < FH && c.pal != 0) begin
            xe = (c.x + c.w < FW) ? c.x + c.w : FW;
            ye = (c.y + c.h < FH) ? c.y + c.h : FH;
            for (int y = c.y; y < ye; y++)
               for (int x = c.x; x < xe; x++)
                  exp_q.push_back(item(1'b1, 1'b0, c.pal, x, y));
         end
      end
      exp_q.push_back(item(1'b0, 1'b1, 0, 0, 0));
   endtask

   function automatic logic [EW-1:0] observed();
      return {busy, frame_done, write_palette,
              (write_palette != 2'd0) ? write_x : 12'd0,
              (write_palette != 2'd0) ? write_y : 12'd0};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check_items(input string tag, input int n);
      logic [EW-1:0] e;
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         tick();
         check(tag, 32'(observed()), 32'(e));
      end
   endtask

   task automatic check_idle(input string tag);
      tick();
      check({tag, "_idle"}, 32'(observed()), 32'(item(1'b0, 1'b0, 0, 0, 0)));
      check({tag, "_overrun"}, 32'(overrun_count), 32'(exp_overrun));
   endtask

   task automatic run_frame(input string tag);
      swap();
      build_frame();
      check_items(tag, exp_q.size());
      check_idle(tag);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_palette", 32'(write_palette), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_overrun", 32'(overrun_count), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);

      run_frame("empty_frame");

      push_cmd(10, 2, 3, 2, 2);
      run_frame("basic_rect");

      push_cmd(FW - 2, FH - 1, 5, 5, 3);
      push_cmd(3, 3, 0, 2, 2);
      push_cmd(FW + 4, 1, 2, 2, 2);
      push_cmd(2, 2, 2, 2, 0);
      run_frame("clip_skip");

      for (int f = 0; f < 3; f++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++)
            push_cmd($urandom_range(0, FW + 3), $urandom_range(0, FH + 3),
                     $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3));
         run_frame("random_frame");
      end

      // Stall in mid-DRAW, then the release edge is a swap that aborts.
      push_cmd(0, 0, FW, FH, 2);
      swap();
      build_frame();
      check_items("abort_pre", NCLR + 6);
      rst_screen_33m = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_palette", 32'(write_palette), 32'd0);
         check("stall_done", 32'(frame_done), 32'd0);
         check("stall_busy", 32'(busy), 32'd1);
         check("stall_overrun", 32'(overrun_count), 32'(exp_overrun));
      end
      rst_screen_33m = 1'b0;
      exp_overrun++;
      build_frame();
      check_items("abort_restart", exp_q.size());
      check_idle("abort_restart");

      // Reset in mid-DRAW drops the frame and clears the overrun count.
      push_cmd(1, 1, 6, 4, 3);
      swap();
      build_frame();
      check_items("reset_pre", NCLR + 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_overrun = 0;
      exp_q.delete();
      cmd_q.delete();
      check_idle("mid_reset");

      // Fill the FIFO, then attempt one more push while full.
      for (int k = 0; k < DEPTH; k++)
         push_cmd(k, k % FH, 2, 1, (k % 3) + 1);
      check("full_ready", 32'(cmd_ready), 32'd0);
      push_cmd(5, 5, 3, 3, 3);
      run_frame("fifo_full");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
